// File: rtl/point_stream_renderer_if.sv
// Output point stream between the renderer and the downstream plotter.
// The renderer drives through master; the plotter consumes through slave.
interface point_stream_renderer_if #(
  parameter int COORD_W = 10
);
  logic               out_valid;
  logic               out_ready;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [7:0]         pixel;

  modport master (output out_valid, x, y, pixel, input out_ready);
  modport slave  (input out_valid, x, y, pixel, output out_ready);
endinterface

// File: rtl/point_stream_renderer.sv
// Streams packed 3D points from ZBT bank 0, applies screen offset and depth shading,
// and buffers them behind a credit-checked FIFO. Define POINT_CLIP_EN to drop off-screen points.
module point_stream_renderer #(
  parameter int ADDR_W     = 19,
  parameter int COORD_W    = 10,
  parameter int ZBT_LAT    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int Z_BIAS     = 350,
  parameter int Z_SHIFT    = 1,
  parameter int SCREEN_W   = 1024,
  parameter int SCREEN_H   = 768
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_points,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [10:0]       x_offset,
  input  logic [10:0]       y_offset,
  input  logic [35:0]       zbt0_read_data,
  output logic [ADDR_W-1:0] zbt0_read_addr,
  output logic              busy,
  output logic              frame_done,
  point_stream_renderer_if.master pts
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ENT_W = 2 * COORD_W + 8;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, rem_q;
  logic [ZBT_LAT-1:0] vld_sr;
  logic [CNT_W-1:0]   in_flight_q, fifo_cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [ENT_W-1:0]   head;
  logic [CNT_W:0]     occ;
  logic               issue, pop, push, credit, unused_hi;

  logic               vld_p0, keep_p0;
  logic [13:0]        xs_p0, ys_p0;
  logic [7:0]         pix_p0;

  function automatic logic [7:0] z_to_pixel(input logic [9:0] z);
    logic [31:0] zs;
    zs = (32'(z) + 32'(Z_BIAS)) << Z_SHIFT;
    if (zs > 32'd1023) zs = 32'd1023;
    return zs[9:2];
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign unused_hi = ^zbt0_read_data[35:30];

  // Stage p0: ZBT word arrives tagged by the valid shift register
  assign vld_p0 = vld_sr[ZBT_LAT-1];
  assign xs_p0  = {4'd0, zbt0_read_data[29:20]} + {x_offset, 3'b000};
  assign ys_p0  = {4'd0, zbt0_read_data[19:10]} + {y_offset, 3'b000};
  assign pix_p0 = z_to_pixel(zbt0_read_data[9:0]);

`ifdef POINT_CLIP_EN
  localparam logic [13:0] SCR_W = 14'(SCREEN_W);
  localparam logic [13:0] SCR_H = 14'(SCREEN_H);
  assign keep_p0 = (xs_p0 < SCR_W) && (ys_p0 < SCR_H);
`else
  localparam int UNUSED_CLIP = SCREEN_W + SCREEN_H;
  assign keep_p0 = 1'b1;
`endif

  assign push = vld_p0 && keep_p0;
  assign pts.out_valid = (fifo_cnt_q != '0);
  assign pop  = pts.out_valid && pts.out_ready;
  // A pop this cycle frees a slot, so it counts as a credit for the new issue
  assign occ    = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
  assign credit = occ < (DEPTH_V + (CNT_W + 1)'(pop));

  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = (num_points == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (credit) begin
          issue = 1'b1;
          if (rem_q == ADDR_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (in_flight_q == '0 &&
            (fifo_cnt_q == '0 || (fifo_cnt_q == CNT_W'(1) && pop)))
          state_d = S_DONE;
      end
      S_DONE: begin
        busy       = 1'b1;
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      vld_sr      <= '0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start && num_points != '0) begin
        addr_q <= base_addr;
        rem_q  <= num_points;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        rem_q  <= rem_q - ADDR_W'(1);
      end
      vld_sr      <= (vld_sr << 1) | ZBT_LAT'(issue);
      in_flight_q <= in_flight_q + CNT_W'(issue) - CNT_W'(vld_p0);
      fifo_cnt_q  <= fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {xs_p0[COORD_W-1:0], ys_p0[COORD_W-1:0], pix_p0};
  end

  assign zbt0_read_addr = addr_q;
  assign head      = fifo_mem[rd_ptr_q];
  assign pts.x     = pts.out_valid ? head[ENT_W-1 -: COORD_W] : '0;
  assign pts.y     = pts.out_valid ? head[7+COORD_W -: COORD_W] : '0;
  assign pts.pixel = pts.out_valid ? head[7:0] : '0;

endmodule

// File: tb/tb_point_stream_renderer.sv
// Directed bench for point_stream_renderer: latency, stalls, shading saturation,
// empty frames, mid-frame reset and offset wrap / clipping.
module tb_point_stream_renderer;
  localparam int ADDR_W  = 19;
  localparam int ZBT_LAT = 2;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [ADDR_W-1:0] num_points, base_addr;
  logic [10:0]       x_offset, y_offset;
  logic [35:0]       zbt0_read_data;
  logic [ADDR_W-1:0] zbt0_read_addr;
  logic              busy, frame_done;

  point_stream_renderer_if #(.COORD_W(10)) pts();

  point_stream_renderer dut (
    .clk(clk), .reset(reset), .start(start), .num_points(num_points),
    .base_addr(base_addr), .x_offset(x_offset), .y_offset(y_offset),
    .zbt0_read_data(zbt0_read_data), .zbt0_read_addr(zbt0_read_addr),
    .busy(busy), .frame_done(frame_done), .pts(pts)
  );

  always #5 clk = ~clk;

  logic [35:0]       zmem [1024];
  logic [ADDR_W-1:0] zd [ZBT_LAT];
  always @(posedge clk) begin
    zd[0] <= zbt0_read_addr;
    for (int i = 1; i < ZBT_LAT; i++) zd[i] <= zd[i-1];
  end
  assign zbt0_read_data = zmem[zd[ZBT_LAT-1][9:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_x[$], q_y[$], q_p[$], q_c[$];
  int fd_cnt = 0, fd_cyc = 0, ov_cnt = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (pts.out_valid) begin
        ov_cnt <= ov_cnt + 1;
        if (pts.out_ready) begin
          q_x.push_back(int'(pts.x));
          q_y.push_back(int'(pts.y));
          q_p.push_back(int'(pts.pixel));
          q_c.push_back(cyc);
        end
      end
      if (frame_done) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc <= cyc;
      end
    end
  end

  int n_vec = 0, n_err = 0, s_cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] word(input int x, input int y, input int z);
    return {6'd0, 10'(x), 10'(y), 10'(z)};
  endfunction

  task automatic pulse_start(input int n, input int base);
    num_points = ADDR_W'(n);
    base_addr  = ADDR_W'(base);
    start      = 1'b1;
    s_cyc      = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int fd0;
    fd0 = fd_cnt;
    for (int i = 0; i < budget; i++) begin
      if (fd_cnt != fd0) break;
      tick();
    end
    chk(tag, fd_cnt - fd0, 1);
    tick();
  endtask

  task automatic clear_q();
    q_x.delete(); q_y.delete(); q_p.delete(); q_c.delete();
  endtask

  initial begin
    int fd_pre, ov_pre, a_pre, n;
    for (int i = 0; i < 1024; i++) zmem[i] = '0;
    reset = 1'b1; start = 1'b0; num_points = '0; base_addr = '0;
    x_offset = '0; y_offset = '0; pts.out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_valid", int'(pts.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_addr", int'(zbt0_read_addr), 0);
    chk("rst_xyp", int'(pts.x) + int'(pts.y) + int'(pts.pixel), 0);

    // basic 4-point frame
    for (int i = 0; i < 4; i++) zmem[10'h100 + i] = word(i, 2 * i, 0);
    clear_q();
    pulse_start(4, 'h100);
    wait_done("t1_done", 40);
    chk("t1_count", q_x.size(), 4);
    for (int i = 0; i < 4 && i < q_x.size(); i++) begin
      chk($sformatf("t1_x%0d", i), q_x[i], i);
      chk($sformatf("t1_y%0d", i), q_y[i], 2 * i);
      chk($sformatf("t1_p%0d", i), q_p[i], 175);
    end
    if (q_c.size() > 0) chk("t1_first_lat", q_c[0] - s_cyc, ZBT_LAT + 2);
    chk("t1_done_lat", fd_cyc - s_cyc, ZBT_LAT + 6);

    // 8-point frame with a 20-cycle downstream stall
    for (int i = 0; i < 8; i++) zmem[10'h200 + i] = word(i + 1, i, 0);
    clear_q();
    pts.out_ready = 1'b0;
    pulse_start(8, 'h200);
    repeat (20) tick();
    chk("t2_none_taken", q_x.size(), 0);
    chk("t2_held_valid", int'(pts.out_valid), 1);
    chk("t2_held_x", int'(pts.x), 1);
    chk("t2_reads_le_depth", int'((zbt0_read_addr - ADDR_W'('h200)) <= 4), 1);
    pts.out_ready = 1'b1;
    wait_done("t2_done", 60);
    chk("t2_count", q_x.size(), 8);
    for (int i = 0; i < 8 && i < q_x.size(); i++)
      chk($sformatf("t2_x%0d", i), q_x[i], i + 1);

    // empty frame
    a_pre  = int'(zbt0_read_addr);
    ov_pre = ov_cnt;
    fd_pre = fd_cnt;
    pulse_start(0, 'h3ff);
    @(negedge clk);
    chk("t3_busy", int'(busy), 1);
    chk("t3_done", int'(frame_done), 1);
    tick();
    chk("t3_idle", int'(busy), 0);
    chk("t3_one_pulse", fd_cnt - fd_pre, 1);
    chk("t3_addr", int'(zbt0_read_addr), a_pre);
    chk("t3_no_valid", ov_cnt - ov_pre, 0);

    // depth saturation and offsets
    zmem[10'h300] = word(5, 3, 1023);
    zmem[10'h301] = word(0, 0, 100);
    x_offset = 11'd1; y_offset = 11'd2;
    clear_q();
    pulse_start(2, 'h300);
    wait_done("t4_done", 40);
    chk("t4_count", q_x.size(), 2);
    if (q_x.size() == 2) begin
      chk("t4_x0", q_x[0], 13);
      chk("t4_y0", q_y[0], 19);
      chk("t4_p_sat", q_p[0], 255);
      chk("t4_x1", q_x[1], 8);
      chk("t4_p_900", q_p[1], 225);
    end

    // offset pushes x past the screen: wrap or clip
    zmem[10'h310] = word(10, 0, 0);
    zmem[10'h311] = word(3, 5, 0);
    x_offset = 11'd127; y_offset = 11'd0;
    clear_q();
    pulse_start(2, 'h310);
    wait_done("t6_done", 40);
`ifdef POINT_CLIP_EN
    chk("t6_count", q_x.size(), 1);
    if (q_x.size() == 1) begin
      chk("t6_x_kept", q_x[0], 1019);
      chk("t6_y_kept", q_y[0], 5);
    end
`else
    chk("t6_count", q_x.size(), 2);
    if (q_x.size() == 2) begin
      chk("t6_x_wrap", q_x[0], 2);
      chk("t6_x_kept", q_x[1], 1019);
    end
`endif
    zmem[10'h320] = word(10, 0, 0);
    x_offset = 11'd0;
    clear_q();
    pulse_start(1, 'h320);
    wait_done("t6b_done", 40);
    chk("t6b_count", q_x.size(), 1);
    if (q_x.size() == 1) chk("t6b_x", q_x[0], 10);

    // reset with two reads in flight, then replay
    for (int i = 0; i < 8; i++) zmem[10'h100 + i] = word(i + 20, 0, 0);
    fd_pre = fd_cnt;
    clear_q();
    pulse_start(8, 'h100);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_valid_cleared", int'(pts.out_valid), 0);
    chk("t5_busy_cleared", int'(busy), 0);
    clear_q();
    pulse_start(2, 'h100);
    wait_done("t5_done", 40);
    n = q_x.size();
    chk("t5_count", n, 2);
    if (n == 2) begin
      chk("t5_x0", q_x[0], 20);
      chk("t5_x1", q_x[1], 21);
    end
    chk("t5_one_done", fd_cnt - fd_pre, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1);
  end
endmodule
